// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
// State encodings are fixed so the arbiter state can be decoded by other tools.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StTurn  = 2'd2
    } arb_state_e;

    // Hold-counter width used when ownership timeout is compiled in.
    localparam int unsigned HoldCntW = 8;

    // Width of the owner / last_owner index, enough for up to 8 requesters.
    localparam int unsigned OwnerW = 3;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between requesters and the bus arbiter.
// master = requester side, slave = arbiter side.
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4
) ();

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   en_n;
    logic [OwnerW-1:0] owner;
    logic              busy;
    logic              tmo;

    modport master (
        output req,
        input  gnt,
        input  en_n,
        input  owner,
        input  busy,
        input  tmo
    );

    modport slave (
        input  req,
        output gnt,
        output en_n,
        output owner,
        output busy,
        output tmo
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: searches from last_owner+1 upwards, wrapping,
// so the previous owner has the lowest priority.
module rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]   i_req,
    input  logic [OwnerW-1:0] i_last_owner,
    output logic [OwnerW-1:0] o_winner,
    output logic              o_valid
);

    always_comb begin
        int unsigned w_idx;
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = 0;
        // k == NREQ lands back on last_owner itself, so a lone requester can win again.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = (32'(i_last_owner) + k) % NREQ;
            if (!o_valid && ((i_req & (NREQ'(1) << w_idx)) != '0)) begin
                o_valid  = 1'b1;
                o_winner = OwnerW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for a shared tristate bus with a one-cycle all-off turnaround.
// Optional ownership timeout is compiled in with `define ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    bus_arbiter_if.slave    bus
);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("bus_arbiter: NREQ must be within 2..8");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > (1 << HoldCntW) - 1) begin : g_bad_hold
        $error("bus_arbiter: MAX_HOLD must be within 2..255");
    end

    arb_state_e        r_state;
    arb_state_e        w_state_d;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   w_win_oh;
    logic [OwnerW-1:0] r_owner;
    logic [OwnerW-1:0] r_last_owner;
    logic [OwnerW-1:0] w_winner;
    logic              w_valid;
    logic              w_issue;
    logic              w_release;
    logic              w_owner_req;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .i_req        (bus.req),
        .i_last_owner (r_last_owner),
        .o_winner     (w_winner),
        .o_valid      (w_valid)
    );

    assign w_win_oh    = NREQ'(1) << w_winner;
    // r_gnt is one-hot on the owner, so this is req[owner] without a wide index.
    assign w_owner_req = |(r_gnt & bus.req);

`ifdef ARB_TIMEOUT_EN
    logic [HoldCntW-1:0] r_hold_cnt;
    logic                w_hold_expired;
    logic                w_tmo_d;
    logic                r_tmo;

    assign w_hold_expired = (r_hold_cnt == HoldCntW'(MAX_HOLD - 1));
`endif

    always_comb begin
        w_state_d = r_state;
        w_issue   = 1'b0;
        w_release = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_tmo_d   = 1'b0;
`endif
        case (r_state)
            StIdle: begin
                if (w_valid) begin
                    w_state_d = StGrant;
                    w_issue   = 1'b1;
                end
            end
            StGrant: begin
                if (!w_owner_req) begin
                    w_state_d = StTurn;
                    w_release = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (w_hold_expired) begin
                    w_state_d = StTurn;
                    w_release = 1'b1;
                    w_tmo_d   = 1'b1;
                end
`endif
            end
            StTurn: begin
                if (w_valid) begin
                    w_state_d = StGrant;
                    w_issue   = 1'b1;
                end else begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_gnt        <= '0;
            r_owner      <= '0;
            r_last_owner <= OwnerW'(NREQ - 1);
        end else begin
            r_state <= w_state_d;
            if (w_issue) begin
                r_gnt        <= w_win_oh;
                r_owner      <= w_winner;
                r_last_owner <= w_winner;
            end else if (w_release) begin
                r_gnt <= '0;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hold_cnt <= '0;
            r_tmo      <= 1'b0;
        end else begin
            r_tmo <= w_tmo_d;
            if (w_issue) begin
                r_hold_cnt <= '0;
            end else if (r_state == StGrant) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign bus.tmo = r_tmo;
`else
    assign bus.tmo = 1'b0;
`endif

    assign bus.gnt   = r_gnt;
    assign bus.en_n  = ~r_gnt;
    assign bus.owner = r_owner;
    assign bus.busy  = (r_state == StGrant);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (NREQ=4, MAX_HOLD=4); expectations track ARB_TIMEOUT_EN.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned MAX_HOLD = 4;

    typedef struct packed {
        logic [3:0] gnt;
        logic       tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.NREQ(NREQ)) bus ();

    bus_arbiter #(
        .NREQ     (NREQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    function automatic logic [2:0] oh_idx(input logic [3:0] v);
        logic [2:0] r = '0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic cycle(input logic [3:0] r, input logic rn);
        bus.req = r;
        rst_n   = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111, 1'b0);
            n_checks++;
            if (bus.gnt !== 4'b0000) begin
                n_errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt);
            end
            n_checks++;
            if (bus.en_n !== 4'b1111) begin
                n_errors++; $display("FAIL reset_en_n: got %b want 1111", bus.en_n);
            end
            n_checks++;
            if (bus.busy !== 1'b0 || bus.tmo !== 1'b0 || bus.owner !== 3'd0) begin
                n_errors++;
                $display("FAIL reset_status: busy=%b tmo=%b owner=%0d want 0 0 0",
                         bus.busy, bus.tmo, bus.owner);
            end
        end
        sb_q.push_back('{gnt: 4'b0001, tmo: 1'b0});
        cycle(4'b1111, 1'b1);
        e = sb_q.pop_front();
        n_checks++;
        if (bus.gnt !== e.gnt || bus.owner !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_first_grant: gnt=%b owner=%0d want %b owner 0",
                     bus.gnt, bus.owner, e.gnt);
        end
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
    endtask

    task automatic test_single();
        logic [3:0] stim[7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic [3:0] expg[7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic       expt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ARB_TIMEOUT_EN
        expg[4] = 4'b0000;
        expt[4] = 1'b1;
`endif
        do_reset();
        for (int i = 0; i < 7; i++) begin
            exp_t e;
            sb_q.push_back('{gnt: expg[i], tmo: expt[i]});
            cycle(stim[i], 1'b1);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.gnt !== e.gnt) begin
                n_errors++; $display("FAIL single_gnt[%0d]: got %b want %b", i, bus.gnt, e.gnt);
            end
            n_checks++;
            if (bus.busy !== (|e.gnt) || bus.tmo !== e.tmo) begin
                n_errors++;
                $display("FAIL single_busy_tmo[%0d]: busy=%b tmo=%b want %b %b",
                         i, bus.busy, bus.tmo, |e.gnt, e.tmo);
            end
            if (e.gnt != 4'b0000) begin
                n_checks++;
                if (bus.owner !== 3'd2) begin
                    n_errors++; $display("FAIL single_owner[%0d]: got %0d want 2", i, bus.owner);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [3:0] stim[19] = '{4'b1111, 4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1111, 4'b1111,
                                 4'b1101, 4'b1111, 4'b1111, 4'b1111, 4'b1011, 4'b1111, 4'b1111,
                                 4'b1111, 4'b0111, 4'b1111, 4'b0000, 4'b0000};
        logic [3:0] expg[19] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010,
                                 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000,
                                 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        logic [3:0] prev = 4'b0000;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            exp_t e;
            sb_q.push_back('{gnt: expg[i], tmo: 1'b0});
            cycle(stim[i], 1'b1);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.gnt !== e.gnt) begin
                n_errors++; $display("FAIL contention_gnt[%0d]: got %b want %b", i, bus.gnt, e.gnt);
            end
            n_checks++;
            if ($countones(~bus.en_n) > 1 || bus.en_n !== ~bus.gnt) begin
                n_errors++;
                $display("FAIL contention_en_n[%0d]: en_n=%b gnt=%b want at most one low, en_n==~gnt",
                         i, bus.en_n, bus.gnt);
            end
            n_checks++;
            if (prev != 4'b0000 && bus.gnt != 4'b0000 && bus.gnt !== prev) begin
                n_errors++;
                $display("FAIL contention_gap[%0d]: gnt %b -> %b want all-off cycle between",
                         i, prev, bus.gnt);
            end
            prev = bus.gnt;
        end
    endtask

    task automatic test_wrap();
        logic [3:0] stim[7] = '{4'b1000, 4'b0000, 4'b1001, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        logic [3:0] expg[7] = '{4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            exp_t e;
            sb_q.push_back('{gnt: expg[i], tmo: 1'b0});
            cycle(stim[i], 1'b1);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.gnt !== e.gnt) begin
                n_errors++; $display("FAIL wrap_gnt[%0d]: got %b want %b", i, bus.gnt, e.gnt);
            end
            if (e.gnt != 4'b0000) begin
                n_checks++;
                if (bus.owner !== oh_idx(e.gnt)) begin
                    n_errors++;
                    $display("FAIL wrap_owner[%0d]: got %0d want %0d", i, bus.owner, oh_idx(e.gnt));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] stim[5] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        logic [3:0] expg[5] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            sb_q.push_back('{gnt: expg[i], tmo: 1'b0});
            cycle(stim[i], 1'b1);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.gnt !== e.gnt || bus.busy !== (|e.gnt)) begin
                n_errors++;
                $display("FAIL b2b[%0d]: gnt=%b busy=%b want %b %b",
                         i, bus.gnt, bus.busy, e.gnt, |e.gnt);
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] expg[14];
        logic       expt[14];
        for (int i = 0; i < 14; i++) begin
            expg[i] = (i < 12) ? 4'b0001 : 4'b0000;
            expt[i] = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        for (int i = 5; i < 9; i++) expg[i] = 4'b0010;
        expg[4]  = 4'b0000;
        expt[4]  = 1'b1;
        expg[9]  = 4'b0000;
        expt[9]  = 1'b1;
`endif
        do_reset();
        for (int i = 0; i < 14; i++) begin
            exp_t e;
            sb_q.push_back('{gnt: expg[i], tmo: expt[i]});
            cycle((i < 12) ? 4'b0011 : 4'b0000, 1'b1);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.gnt !== e.gnt) begin
                n_errors++; $display("FAIL timeout_gnt[%0d]: got %b want %b", i, bus.gnt, e.gnt);
            end
            n_checks++;
            if (bus.tmo !== e.tmo) begin
                n_errors++; $display("FAIL timeout_tmo[%0d]: got %b want %b", i, bus.tmo, e.tmo);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] stim[6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0000, 4'b0000};
        logic       rstv[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] expg[6] = '{4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            sb_q.push_back('{gnt: expg[i], tmo: 1'b0});
            cycle(stim[i], rstv[i]);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.gnt !== e.gnt || bus.busy !== (|e.gnt)) begin
                n_errors++;
                $display("FAIL reset_mid[%0d]: gnt=%b busy=%b want %b %b",
                         i, bus.gnt, bus.busy, e.gnt, |e.gnt);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.req = '0;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
